// File: rtl/inv_sub_bytes_iter.sv
// rtl/inv_sub_bytes_iter.sv - iterative AES InvSubBytes, LANES S-box lookups per cycle
// INV_SUB_BYTES_FWD_EN adds a latched mode input selecting forward (0) or inverse (1) S-box.
module inv_sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
`ifdef INV_SUB_BYTES_FWD_EN
    input  logic         mode,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout,
    output logic         busy
);
    localparam int NCHUNK = 16 / LANES;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

`ifdef INV_SUB_BYTES_FWD_EN
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    logic mode_q;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt;
    logic [127:0]    work, next_work;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // in_ready is gated by rst_n so it reads low for the whole reset window
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) state_d = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt == LAST) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Chunk k covers bytes k*LANES .. k*LANES+LANES-1; all other bytes pass through
    always_comb begin
        next_work = work;
        for (int l = 0; l < LANES; l++) begin
`ifdef INV_SUB_BYTES_FWD_EN
            next_work[(int'(cnt) * LANES + l) * 8 +: 8] = mode_q
                ? INV_SBOX[work[(int'(cnt) * LANES + l) * 8 +: 8]]
                : SBOX[work[(int'(cnt) * LANES + l) * 8 +: 8]];
`else
            next_work[(int'(cnt) * LANES + l) * 8 +: 8] = INV_SBOX[work[(int'(cnt) * LANES + l) * 8 +: 8]];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            cnt  <= '0;
            dout <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
            mode_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work <= din;
                        cnt  <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
                        mode_q <= mode;
`endif
                    end
                end
                BUSY: begin
                    work <= next_work;
                    if (cnt == LAST) begin
                        dout <= next_work;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb/tb_inv_sub_bytes_iter.sv - scoreboard bench for inv_sub_bytes_iter at LANES 4, 1 and 16
// Instance 0 (LANES=4) takes the directed tests; the reference S-box is computed from GF(2^8) arithmetic.
module tb_inv_sub_bytes_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [2:0]        in_valid_s = '0;
    logic [2:0]        out_ready_s = '0;
    logic [2:0][127:0] din_s = '0;
    logic [2:0]        in_ready_s, out_valid_s, busy_s;
    logic [2:0][127:0] dout_s;
`ifdef INV_SUB_BYTES_FWD_EN
    logic [2:0]        mode_s = '1;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_sub_bytes_iter #(.LANES(g == 0 ? 4 : (g == 1 ? 1 : 16))) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_s[g]),
            .in_ready  (in_ready_s[g]),
            .din       (din_s[g]),
`ifdef INV_SUB_BYTES_FWD_EN
            .mode      (mode_s[g]),
`endif
            .out_valid (out_valid_s[g]),
            .out_ready (out_ready_s[g]),
            .dout      (dout_s[g]),
            .busy      (busy_s[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        for (int k = 0; k < 254; k++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] inv_byte(input logic [7:0] y);
        return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] fwd_byte(input logic [7:0] x);
        logic [7:0] b = ginv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] inv_state(input logic [127:0] s);
        logic [127:0] r = '0;
        for (int b = 0; b < 16; b++) r[b * 8 +: 8] = inv_byte(s[b * 8 +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] fwd_state(input logic [127:0] s);
        logic [127:0] r = '0;
        for (int b = 0; b < 16; b++) r[b * 8 +: 8] = fwd_byte(s[b * 8 +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [127:0] d, input logic fwd);
        din_s[i] = d;
        in_valid_s[i] = 1'b1;
        exp_q.push_back(fwd ? fwd_state(d) : inv_state(d));
        tick();
        in_valid_s[i] = 1'b0;
    endtask

    task automatic wait_out(input int i, input int budget, output int n, output logic ready_seen);
        n = 0;
        ready_seen = 1'b0;
        while (!out_valid_s[i] && n < budget) begin
            if (in_ready_s[i]) ready_seen = 1'b1;
            tick();
            n++;
        end
    endtask

    task automatic release_out(input int i);
        out_ready_s[i] = 1'b1;
        tick();
        out_ready_s[i] = 1'b0;
    endtask

    function automatic logic [127:0] pop_exp();
        return (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    endfunction

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        for (int g = 0; g < 3; g++) begin
            vectors++; if (in_ready_s[g] !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready[%0d]: got %b, want 0", g, in_ready_s[g]); end
            vectors++; if (out_valid_s[g] !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid[%0d]: got %b, want 0", g, out_valid_s[g]); end
            vectors++; if (dout_s[g] !== 128'h0) begin miscompares++; $display("FAIL reset_dout[%0d]: got %h, want 0", g, dout_s[g]); end
            vectors++; if (busy_s[g] !== 1'b0) begin miscompares++; $display("FAIL reset_busy[%0d]: got %b, want 0", g, busy_s[g]); end
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        vectors++; if (in_ready_s !== 3'b111) begin miscompares++; $display("FAIL reset_release_in_ready: got %b, want 111", in_ready_s); end
    endtask

    task automatic test_basic();
        int n;
        logic rs;
        logic [127:0] e;
        send(0, {16{8'h63}}, 1'b0);
        vectors++; if (busy_s[0] !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b, want 1", busy_s[0]); end
        din_s[0] = rand128();
        wait_out(0, 40, n, rs);
        vectors++; if (n !== 4) begin miscompares++; $display("FAIL basic_latency: got %0d, want 4", n); end
        vectors++; if (rs !== 1'b0 || in_ready_s[0] !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready_low: got %b/%b, want 0/0", rs, in_ready_s[0]); end
        e = pop_exp();
        vectors++; if (dout_s[0] !== e) begin miscompares++; $display("FAIL basic_model: got %h, want %h", dout_s[0], e); end
        vectors++; if (dout_s[0] !== 128'h0) begin miscompares++; $display("FAIL basic_const: got %h, want 0", dout_s[0]); end
        release_out(0);
        vectors++; if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1) begin miscompares++; $display("FAIL basic_handshake: got ov=%b ir=%b, want ov=0 ir=1", out_valid_s[0], in_ready_s[0]); end
    endtask

    task automatic test_byte_order();
        int n;
        logic rs;
        logic [127:0] e;
        logic [127:0] want = {{12{8'h52}}, 32'hff530100};
        send(0, {96'h0, 32'h16ed7c63}, 1'b0);
        wait_out(0, 40, n, rs);
        e = pop_exp();
        vectors++; if (dout_s[0] !== want) begin miscompares++; $display("FAIL order_const: got %h, want %h", dout_s[0], want); end
        vectors++; if (dout_s[0] !== e) begin miscompares++; $display("FAIL order_model: got %h, want %h", dout_s[0], e); end
        release_out(0);
    endtask

    task automatic test_stall();
        int n;
        logic rs;
        logic [127:0] e;
        send(0, rand128(), 1'b0);
        din_s[0] = rand128();
        in_valid_s[0] = 1'b1;
        wait_out(0, 40, n, rs);
        e = pop_exp();
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (out_valid_s[0] !== 1'b1 || in_ready_s[0] !== 1'b0 || dout_s[0] !== e) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got ov=%b ir=%b dout=%h, want ov=1 ir=0 dout=%h", c, out_valid_s[0], in_ready_s[0], dout_s[0], e);
            end
            din_s[0] = rand128();
            tick();
        end
        in_valid_s[0] = 1'b0;
        release_out(0);
        vectors++; if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1) begin miscompares++; $display("FAIL stall_release: got ov=%b ir=%b, want ov=0 ir=1", out_valid_s[0], in_ready_s[0]); end
    endtask

    task automatic test_reset_mid();
        int spurious = 0;
        send(0, rand128(), 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid_s[0] !== 1'b0 || dout_s[0] !== 128'h0 || busy_s[0] !== 1'b0 || in_ready_s[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got ov=%b busy=%b ir=%b dout=%h, want all 0", out_valid_s[0], busy_s[0], in_ready_s[0], dout_s[0]);
        end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        #1;
        vectors++; if (in_ready_s[0] !== 1'b1) begin miscompares++; $display("FAIL midreset_in_ready: got %b, want 1", in_ready_s[0]); end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid_s[0] !== 1'b0) spurious++;
        end
        vectors++; if (spurious != 0) begin miscompares++; $display("FAIL midreset_spurious: got %0d out_valid cycles, want 0", spurious); end
    endtask

    task automatic test_back_to_back(input int i, input int nchunk);
        int cyc = 0;
        int got = 0;
        int sent = 0;
        int acc_edge = 0;
        int last_out = -1;
        int budget = 16 * (nchunk + 2) + 40;
        logic acc;
        logic [127:0] e;
        out_ready_s[i] = 1'b1;
        din_s[i] = rand128();
        in_valid_s[i] = 1'b1;
        while (got < 16 && cyc < budget) begin
            acc = in_valid_s[i] & in_ready_s[i];
            if (out_valid_s[i]) begin
                e = pop_exp();
                vectors++; if (dout_s[i] !== e) begin miscompares++; $display("FAIL b2b_data[L%0d #%0d]: got %h, want %h", 16 / nchunk, got, dout_s[i], e); end
                vectors++; if (cyc - acc_edge != nchunk) begin miscompares++; $display("FAIL b2b_latency[L%0d #%0d]: got %0d, want %0d", 16 / nchunk, got, cyc - acc_edge, nchunk); end
                if (last_out >= 0) begin
                    vectors++; if (cyc - last_out != nchunk + 2) begin miscompares++; $display("FAIL b2b_period[L%0d #%0d]: got %0d, want %0d", 16 / nchunk, got, cyc - last_out, nchunk + 2); end
                end
                last_out = cyc;
                got++;
            end
            tick();
            cyc++;
            if (acc) begin
                exp_q.push_back(inv_state(din_s[i]));
                acc_edge = cyc;
                sent++;
                if (sent == 16) in_valid_s[i] = 1'b0;
                else din_s[i] = rand128();
            end
        end
        vectors++; if (got != 16) begin miscompares++; $display("FAIL b2b_count[L%0d]: got %0d blocks, want 16", 16 / nchunk, got); end
        tick();
        in_valid_s[i] = 1'b0;
        out_ready_s[i] = 1'b0;
        exp_q.delete();
    endtask

`ifdef INV_SUB_BYTES_FWD_EN
    task automatic test_mode();
        int n;
        logic rs;
        logic [127:0] e;
        logic [127:0] d;
        mode_s[0] = 1'b0;
        send(0, 128'h0, 1'b1);
        wait_out(0, 40, n, rs);
        e = pop_exp();
        vectors++; if (dout_s[0] !== {16{8'h63}} || dout_s[0] !== e) begin miscompares++; $display("FAIL mode_fwd: got %h, want %h", dout_s[0], e); end
        release_out(0);
        mode_s[0] = 1'b1;
        send(0, {16{8'h63}}, 1'b0);
        wait_out(0, 40, n, rs);
        e = pop_exp();
        vectors++; if (dout_s[0] !== 128'h0 || dout_s[0] !== e) begin miscompares++; $display("FAIL mode_inv: got %h, want %h", dout_s[0], e); end
        release_out(0);
        d = rand128();
        mode_s[0] = 1'b0;
        send(0, d, 1'b1);
        tick();
        mode_s[0] = 1'b1;
        wait_out(0, 40, n, rs);
        e = pop_exp();
        vectors++; if (dout_s[0] !== e || n !== 3) begin miscompares++; $display("FAIL mode_toggle: got %h after %0d, want %h after 3", dout_s[0], n, e); end
        release_out(0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_byte_order();
        test_stall();
        test_reset_mid();
        test_back_to_back(0, 4);
        test_back_to_back(1, 16);
        test_back_to_back(2, 1);
`ifdef INV_SUB_BYTES_FWD_EN
        test_mode();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
